pipe_stage_skid: RTL and testbench

//  Parametrised inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//  It replaces the fixed-field enable/reset stage flops between IF/ID/EX/MEM/WB.

---
 rtl/pipe_stage_skid.sv | 191 +++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and saturating transfer/stall counters.
module pipe_stage_skid #(
    parameter int unsigned        DATA_W      = 200,
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_xfer_cnt,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] main_nxt_s;
    logic [DATA_W-1:0] skid_r;
    logic [DATA_W-1:0] skid_nxt_s;
    logic              valid_r;
    logic              valid_nxt_s;
    logic              ready_r;
    logic              ready_nxt_s;
    logic [1:0]        occ_r;
    logic [1:0]        occ_nxt_s;
    logic [CNT_W-1:0]  xfer_r;
    logic [CNT_W-1:0]  xfer_nxt_s;
    logic [CNT_W-1:0]  stall_r;
    logic [CNT_W-1:0]  stall_nxt_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              stall_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    // o_ready is a registered flag, so in_fire never depends combinationally on i_ready.
    assign in_fire_s  = i_valid & ready_r;
    assign out_fire_s = valid_r & i_ready;
    assign stall_s    = valid_r & ~i_ready;

    // Next-state and storage selection; flush squashes everything back to a bubble.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (i_flush) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = BUBBLE_DATA;
            skid_nxt_s  = BUBBLE_DATA;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s = ST_BUSY;
                        main_nxt_s  = i_data;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        state_nxt_s = ST_BUSY;
                        main_nxt_s  = i_data;
                    end else if (in_fire_s) begin
                        state_nxt_s = ST_FULL;
                        skid_nxt_s  = i_data;
                    end else if (out_fire_s) begin
                        state_nxt_s = ST_EMPTY;
                        main_nxt_s  = BUBBLE_DATA;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    // o_ready is low here, so only the drain path can move the state.
                    if (out_fire_s) begin
                        state_nxt_s = ST_BUSY;
                        main_nxt_s  = skid_r;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    main_nxt_s  = BUBBLE_DATA;
                    skid_nxt_s  = BUBBLE_DATA;
                end
            endcase
        end
    end

    // Handshake flags and occupancy decoded from the next state so they can be registered.
    always_comb begin
        valid_nxt_s = 1'b0;
        ready_nxt_s = 1'b1;
        occ_nxt_s   = 2'd0;
        case (state_nxt_s)
            ST_EMPTY: begin
                valid_nxt_s = 1'b0;
                ready_nxt_s = 1'b1;
                occ_nxt_s   = 2'd0;
            end
            ST_BUSY: begin
                valid_nxt_s = 1'b1;
                ready_nxt_s = 1'b1;
                occ_nxt_s   = 2'd1;
            end
            ST_FULL: begin
                valid_nxt_s = 1'b1;
                ready_nxt_s = 1'b0;
                occ_nxt_s   = 2'd2;
            end
            default: begin
                valid_nxt_s = 1'b0;
                ready_nxt_s = 1'b1;
                occ_nxt_s   = 2'd0;
            end
        endcase
    end

    // Performance counters keep running through a flush; an out_fire on the flush cycle still counts.
    always_comb begin
        xfer_nxt_s  = xfer_r;
        stall_nxt_s = stall_r;
        if (out_fire_s) begin
            xfer_nxt_s = sat_inc(xfer_r);
        end else begin
            xfer_nxt_s = xfer_r;
        end
        if (stall_s) begin
            stall_nxt_s = sat_inc(stall_r);
        end else begin
            stall_nxt_s = stall_r;
        end
    end

    // State, storage, flags and counters; reset has priority over flush and handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_EMPTY;
            main_r  <= BUBBLE_DATA;
            skid_r  <= BUBBLE_DATA;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            occ_r   <= 2'd0;
            xfer_r  <= {CNT_W{1'b0}};
            stall_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            main_r  <= main_nxt_s;
            skid_r  <= skid_nxt_s;
            valid_r <= valid_nxt_s;
            ready_r <= ready_nxt_s;
            occ_r   <= occ_nxt_s;
            xfer_r  <= xfer_nxt_s;
            stall_r <= stall_nxt_s;
        end
    end

    // main_r holds BUBBLE_DATA whenever the stage is empty, so it drives o_data directly.
    assign o_data      = main_r;
    assign o_valid     = valid_r;
    assign o_ready     = ready_r;
    assign o_occupancy = occ_r;
    assign o_xfer_cnt  = xfer_r;
    assign o_stall_cnt = stall_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded checks for pipe_stage_skid: streaming, backpressure,
// flush, reset while full, counter saturation and a randomized FIFO-order run.
module tb_pipe_stage_skid;

    localparam int unsigned    DW  = 32;
    localparam logic [DW-1:0]  BUB = 32'h0000_0013;
    localparam int             N_ITEMS = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_reset, a_flush, a_ivalid, a_oready, a_ovalid, a_iready;
    logic [DW-1:0] a_idata, a_odata;
    logic [1:0]    a_occ;
    logic [15:0]   a_xfer, a_stall;

    logic          b_reset, b_flush, b_ivalid, b_oready, b_ovalid, b_iready;
    logic [DW-1:0] b_idata, b_odata;
    logic [1:0]    b_occ;
    logic [3:0]    b_xfer, b_stall;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_skid #(.DATA_W(DW), .BUBBLE_DATA(BUB), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_reset(a_reset), .i_flush(a_flush),
        .i_valid(a_ivalid), .o_ready(a_oready), .i_data(a_idata),
        .o_valid(a_ovalid), .i_ready(a_iready), .o_data(a_odata),
        .o_occupancy(a_occ), .o_xfer_cnt(a_xfer), .o_stall_cnt(a_stall)
    );

    pipe_stage_skid #(.DATA_W(DW), .BUBBLE_DATA(BUB), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_reset(b_reset), .i_flush(b_flush),
        .i_valid(b_ivalid), .o_ready(b_oready), .i_data(b_idata),
        .o_valid(b_ovalid), .i_ready(b_iready), .o_data(b_odata),
        .o_occupancy(b_occ), .o_xfer_cnt(b_xfer), .o_stall_cnt(b_stall)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_reset_state(input string tag);
        check_eq({tag, "_valid"}, 64'(a_ovalid), 64'd0);
        check_eq({tag, "_ready"}, 64'(a_oready), 64'd1);
        check_eq({tag, "_occ"},   64'(a_occ),    64'd0);
        check_eq({tag, "_data"},  64'(a_odata),  64'(BUB));
        check_eq({tag, "_xfer"},  64'(a_xfer),   64'd0);
        check_eq({tag, "_stall"}, 64'(a_stall),  64'd0);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        int            pushed;
        int            popped;
        int            cyc;
        int            stalls;
        bit            v;
        bit            r;
        bit            fire_in;
        bit            fire_out;

        a_reset = 1'b1; a_flush = 1'b0; a_ivalid = 1'b0; a_iready = 1'b0; a_idata = '0;
        b_reset = 1'b1; b_flush = 1'b0; b_ivalid = 1'b0; b_iready = 1'b0; b_idata = '0;
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;
        check_a_reset_state("rst");

        // 1: back-to-back stream 0x01..0x08
        for (int k = 1; k <= 8; k++) begin
            a_ivalid = 1'b1; a_idata = DW'(k); a_iready = 1'b1;
            tick();
            check_eq("t1_data",  64'(a_odata),  64'(k));
            check_eq("t1_valid", 64'(a_ovalid), 64'd1);
            check_eq("t1_occ",   64'(a_occ),    64'd1);
        end
        a_ivalid = 1'b0; a_idata = 32'hDEAD_BEEF;
        tick();
        check_eq("t1_xfer",  64'(a_xfer),   64'd8);
        check_eq("t1_stall", 64'(a_stall),  64'd0);
        check_eq("t1_empty", 64'(a_ovalid), 64'd0);
        check_eq("t1_bub",   64'(a_odata),  64'(BUB));

        // 2: backpressure into the skid register
        a_iready = 1'b0;
        a_ivalid = 1'b1; a_idata = 32'hA0;
        tick();
        check_eq("t2_occ1",  64'(a_occ),    64'd1);
        check_eq("t2_rdy1",  64'(a_oready), 64'd1);
        check_eq("t2_d0",    64'(a_odata),  64'hA0);
        a_idata = 32'hA1;
        tick();
        check_eq("t2_occ2",  64'(a_occ),    64'd2);
        check_eq("t2_rdy0",  64'(a_oready), 64'd0);
        a_idata = 32'hA2;
        tick();
        check_eq("t2_hold",  64'(a_odata),  64'hA0);
        check_eq("t2_occh",  64'(a_occ),    64'd2);
        tick();
        check_eq("t2_stall", 64'(a_stall),  64'd3);
        a_iready = 1'b1;
        tick();
        check_eq("t2_d1",    64'(a_odata),  64'hA1);
        check_eq("t2_occd",  64'(a_occ),    64'd1);
        check_eq("t2_x9",    64'(a_xfer),   64'd9);
        tick();
        check_eq("t2_d2",    64'(a_odata),  64'hA2);
        check_eq("t2_x10",   64'(a_xfer),   64'd10);
        a_ivalid = 1'b0;
        tick();
        check_eq("t2_end",   64'(a_ovalid), 64'd0);
        check_eq("t2_x11",   64'(a_xfer),   64'd11);
        check_eq("t2_st3",   64'(a_stall),  64'd3);

        // 3: flush while FULL
        a_iready = 1'b0;
        a_ivalid = 1'b1; a_idata = 32'hB0;
        tick();
        a_idata = 32'hB1;
        tick();
        check_eq("t3_full",  64'(a_occ),    64'd2);
        a_ivalid = 1'b0; a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check_eq("t3_valid", 64'(a_ovalid), 64'd0);
        check_eq("t3_data",  64'(a_odata),  64'(BUB));
        check_eq("t3_ready", 64'(a_oready), 64'd1);
        check_eq("t3_occ",   64'(a_occ),    64'd0);
        check_eq("t3_xfer",  64'(a_xfer),   64'd11);
        check_eq("t3_stall", 64'(a_stall),  64'd5);
        a_iready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t3_gone",  64'(a_ovalid), 64'd0);
        end
        check_eq("t3_xfer2", 64'(a_xfer), 64'd11);

        // 3b: out_fire coinciding with a flush is still counted
        a_ivalid = 1'b1; a_idata = 32'hC0;
        tick();
        a_ivalid = 1'b0; a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check_eq("t3b_xfer",  64'(a_xfer),   64'd12);
        check_eq("t3b_valid", 64'(a_ovalid), 64'd0);

        // 4: reset while FULL with downstream ready
        a_iready = 1'b0;
        a_ivalid = 1'b1; a_idata = 32'hD0;
        tick();
        a_idata = 32'hD1;
        tick();
        check_eq("t4_full",  64'(a_occ),   64'd2);
        check_eq("t4_stall", 64'(a_stall), 64'd6);
        a_ivalid = 1'b0; a_iready = 1'b1; a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        check_a_reset_state("t4");

        // 5: 4-bit counters saturate
        b_ivalid = 1'b1; b_idata = 32'h55; b_iready = 1'b0;
        tick();
        b_ivalid = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            check_eq("t5_stall", 64'(b_stall), 64'((t < 15) ? t : 15));
        end
        check_eq("t5_xfer0", 64'(b_xfer), 64'd0);
        b_iready = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            b_ivalid = 1'b1; b_idata = DW'(t);
            tick();
        end
        check_eq("t5_xfer",   64'(b_xfer),  64'd15);
        check_eq("t5_stall2", 64'(b_stall), 64'd15);

        // 6: random handshake against a queue model
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        pushed = 0; popped = 0; cyc = 0; stalls = 0;
        while (popped < N_ITEMS && cyc < 80000) begin
            check_eq("sb_occ",   64'(a_occ),    64'(q.size()));
            check_eq("sb_valid", 64'(a_ovalid), 64'(q.size() != 0));
            check_eq("sb_ready", 64'(a_oready), 64'(q.size() != 2));
            if (q.size() != 0) begin
                check_eq("sb_data", 64'(a_odata), 64'(q[0]));
            end else begin
                check_eq("sb_bub",  64'(a_odata), 64'(BUB));
            end
            v = (pushed < N_ITEMS) && ($urandom_range(1, 0) == 1);
            r = ($urandom_range(1, 0) == 1);
            a_ivalid = v; a_iready = r; a_idata = $urandom;
            fire_out = (q.size() != 0) && r;
            fire_in  = v && (q.size() != 2);
            if (q.size() != 0 && !r) stalls++;
            if (fire_out) begin
                void'(q.pop_front());
                popped++;
            end
            if (fire_in) begin
                q.push_back(a_idata);
                pushed++;
            end
            tick();
            cyc++;
        end
        check_eq("sb_timeout", 64'(popped), 64'(N_ITEMS));
        check_eq("sb_xfer",    64'(a_xfer),  64'(N_ITEMS));
        check_eq("sb_stall",   64'(a_stall), 64'(stalls));
        a_ivalid = 1'b0; a_iready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
